square_accr_arbiter: RTL

SQUARE_ACCR_ARBITER -- requirements
Module: square_accr_arbiter

---
 rtl/square_accr_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/square_accr_arbiter.sv
// Two-requester arbiter that shares one accumulator engine. It applies a
// fairness tie-break, times out a hung engine and holds each response until the consumer takes it.
module square_accr_arbiter #(
    parameter int unsigned TIMEOUT = 200
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req0_valid,
    input  logic       req1_valid,
    input  logic [3:0] req0_N,
    input  logic [3:0] req1_N,
    output logic       req0_ready,
    output logic       req1_ready,
    output logic [3:0] eng_N,
    output logic       eng_N_valid,
    input  logic [7:0] eng_sum,
    input  logic       eng_sum_valid,
    output logic       rsp_valid,
    output logic       rsp_id,
    output logic [7:0] rsp_sum,
    output logic       rsp_err,
    input  logic       rsp_ready,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [7:0] TMAX = 8'(TIMEOUT - 1);

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_n;
    logic       r_id;
    logic [7:0] r_timer;
    logic [7:0] r_sum;
    logic       r_err;
    logic       r_last_grant;
    logic       w_grant0;
    logic       w_grant1;
    logic       w_timeout;

    // A tie goes to whichever requester was not served last.
    assign w_grant0  = req0_valid & (~req1_valid | r_last_grant);
    assign w_grant1  = req1_valid & (~req0_valid | ~r_last_grant);
    assign w_timeout = (r_timer == TMAX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        eng_N_valid = 1'b0;
        rsp_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Ready is combinational, so it is masked while reset is held.
                req0_ready = w_grant0 & reset_n;
                req1_ready = w_grant1 & reset_n;
                if (w_grant0 || w_grant1) begin
                    w_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                eng_N_valid = 1'b1;
                w_next      = S_WAIT;
            end
            S_WAIT: begin
                if (eng_sum_valid || w_timeout) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign busy    = (r_state != S_IDLE);
    assign eng_N   = (r_state == S_ISSUE || r_state == S_WAIT) ? r_n : '0;
    assign rsp_id  = rsp_valid & r_id;
    assign rsp_sum = rsp_valid ? r_sum : '0;
    assign rsp_err = rsp_valid & r_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_n          <= '0;
            r_id         <= 1'b0;
            r_timer      <= '0;
            r_sum        <= '0;
            r_err        <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant0 || w_grant1) begin
                        r_n  <= w_grant1 ? req1_N : req0_N;
                        r_id <= w_grant1;
                    end
                end
                S_ISSUE: begin
                    r_timer <= '0;
                end
                S_WAIT: begin
                    r_timer <= r_timer + 8'd1;
                    // A result arriving on the timeout cycle still counts as valid.
                    if (eng_sum_valid) begin
                        r_sum <= eng_sum;
                        r_err <= 1'b0;
                    end else if (w_timeout) begin
                        r_sum <= '0;
                        r_err <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_last_grant <= r_id;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
